// File: rtl/pipe_hazard_unit_if.sv
// Signal bundle between the pipeline stage modules and the hazard/forwarding unit.
// The master side is the datapath and the slave side is pipe_hazard_unit.
interface pipe_hazard_unit_if #(
    parameter int unsigned N     = 64,
    parameter int unsigned A     = 5,
    parameter int unsigned CNT_W = 32
);
    logic             valid_D;
    logic [A-1:0]     rs1_D, rs2_D;
    logic             usesRs1_D, usesRs2_D;
    logic [A-1:0]     rd_D;
    logic             regWrite_D, memRead_D;
    logic             PCSrc_E;
    logic [N-1:0]     readData1_E, readData2_E;
    logic [N-1:0]     aluResult_M, writeData3_W;
    logic             stall_F, stall_D, flush_D, flush_E;
    logic [1:0]       fwdSel1_E, fwdSel2_E;
    logic [N-1:0]     fwdData1_E, fwdData2_E;
    logic [CNT_W-1:0] stallCount, flushCount;

    modport master (
        output valid_D, rs1_D, rs2_D, usesRs1_D, usesRs2_D, rd_D, regWrite_D, memRead_D,
        output PCSrc_E, readData1_E, readData2_E, aluResult_M, writeData3_W,
        input  stall_F, stall_D, flush_D, flush_E, fwdSel1_E, fwdSel2_E,
        input  fwdData1_E, fwdData2_E, stallCount, flushCount
    );

    modport slave (
        input  valid_D, rs1_D, rs2_D, usesRs1_D, usesRs2_D, rd_D, regWrite_D, memRead_D,
        input  PCSrc_E, readData1_E, readData2_E, aluResult_M, writeData3_W,
        output stall_F, stall_D, flush_D, flush_E, fwdSel1_E, fwdSel2_E,
        output fwdData1_E, fwdData2_E, stallCount, flushCount
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and E-stage operand forwarding for the five-stage F/D/E/M/W pipeline.
// Tracks register metadata of the E, M and W instructions; holds no data beyond forwarded operands.
module pipe_hazard_unit #(
    parameter int unsigned N      = 64,
    parameter int unsigned A      = 5,
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz
);
    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_W  = 2'b01,
        SEL_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic         valid;
        logic [A-1:0] rs1;
        logic [A-1:0] rs2;
        logic         uses_rs1;
        logic         uses_rs2;
        logic [A-1:0] rd;
        logic         reg_write;
        logic         mem_read;
    } e_rec_t;

    // M and W keep only the fields still consulted once an instruction has left E.
    typedef struct packed {
        logic         valid;
        logic [A-1:0] rd;
        logic         reg_write;
        logic         mem_read;
    } m_rec_t;

    typedef struct packed {
        logic         valid;
        logic [A-1:0] rd;
        logic         reg_write;
    } w_rec_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    e_rec_t           e_q, e_d;
    m_rec_t           m_q, m_d;
    w_rec_t           w_q, w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             e_writer, m_writer, w_writer;
    logic             d_hits_e, d_hits_m, hazard;
    logic             redirect, stall, flush_e;
    fwd_sel_e         sel1, sel2;
    logic [N-1:0]     fwd_data1, fwd_data2;

    function automatic fwd_sel_e pick_src(input logic used, input logic [A-1:0] src,
                                          input logic m_ok, input logic [A-1:0] m_rd,
                                          input logic w_ok, input logic [A-1:0] w_rd);
        if (!used)
            return SEL_RF;
        if (m_ok && (m_rd == src))
            return SEL_M;
        if (w_ok && (w_rd == src))
            return SEL_W;
        return SEL_RF;
    endfunction

    always_comb begin
        e_writer = e_q.valid && e_q.reg_write && (e_q.rd != '0);
        m_writer = m_q.valid && m_q.reg_write && (m_q.rd != '0);
        w_writer = w_q.valid && w_q.reg_write && (w_q.rd != '0);

        d_hits_e = e_writer && ((hz.usesRs1_D && (hz.rs1_D == e_q.rd)) ||
                                (hz.usesRs2_D && (hz.rs2_D == e_q.rd)));
        d_hits_m = m_writer && ((hz.usesRs1_D && (hz.rs1_D == m_q.rd)) ||
                                (hz.usesRs2_D && (hz.rs2_D == m_q.rd)));

        if (FWD_EN)
            hazard = d_hits_e && e_q.mem_read;
        else
            hazard = d_hits_e || d_hits_m;

        // Reset is folded in so that flushes driven from PCSrc_E also drop while reset is held.
        redirect = reset && hz.PCSrc_E;
        stall    = reset && hz.valid_D && hazard && !hz.PCSrc_E;
        flush_e  = redirect || stall;

        sel1 = SEL_RF;
        sel2 = SEL_RF;
        if (FWD_EN && e_q.valid) begin
            sel1 = pick_src(e_q.uses_rs1, e_q.rs1, m_writer && !m_q.mem_read, m_q.rd,
                            w_writer, w_q.rd);
            sel2 = pick_src(e_q.uses_rs2, e_q.rs2, m_writer && !m_q.mem_read, m_q.rd,
                            w_writer, w_q.rd);
        end

        unique case (sel1)
            SEL_M:   fwd_data1 = hz.aluResult_M;
            SEL_W:   fwd_data1 = hz.writeData3_W;
            default: fwd_data1 = hz.readData1_E;
        endcase
        unique case (sel2)
            SEL_M:   fwd_data2 = hz.aluResult_M;
            SEL_W:   fwd_data2 = hz.writeData3_W;
            default: fwd_data2 = hz.readData2_E;
        endcase
    end

    always_comb begin
        e_d = '0;
        if (hz.valid_D && !flush_e) begin
            e_d.valid     = 1'b1;
            e_d.rs1       = hz.rs1_D;
            e_d.rs2       = hz.rs2_D;
            e_d.uses_rs1  = hz.usesRs1_D;
            e_d.uses_rs2  = hz.usesRs2_D;
            e_d.rd        = hz.rd_D;
            e_d.reg_write = hz.regWrite_D;
            e_d.mem_read  = hz.memRead_D;
        end

        m_d           = '0;
        m_d.valid     = e_q.valid;
        m_d.rd        = e_q.rd;
        m_d.reg_write = e_q.reg_write;
        m_d.mem_read  = e_q.mem_read;

        w_d           = '0;
        w_d.valid     = m_q.valid;
        w_d.rd        = m_q.rd;
        w_d.reg_write = m_q.reg_write;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        flush_cnt_d = flush_cnt_q;
        if (redirect && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_F    = stall;
    assign hz.stall_D    = stall;
    assign hz.flush_D    = redirect;
    assign hz.flush_E    = flush_e;
    assign hz.fwdSel1_E  = sel1;
    assign hz.fwdSel2_E  = sel2;
    assign hz.fwdData1_E = fwd_data1;
    assign hz.fwdData2_E = fwd_data2;
    assign hz.stallCount = stall_cnt_q;
    assign hz.flushCount = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: a forwarding instance and a stall-only instance with 2-bit counters,
// both driven identically and compared against an instruction-history reference model.
module tb_pipe_hazard_unit;
    localparam int N = 64;
    localparam int A = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         valid_D, u1, u2, rw, mr, pc;
    logic [A-1:0] rs1, rs2, rd;
    logic [N-1:0] rd1, rd2, alu, wb;

    pipe_hazard_unit_if #(.N(N), .A(A), .CNT_W(32)) bf ();
    pipe_hazard_unit_if #(.N(N), .A(A), .CNT_W(2))  bs ();

    pipe_hazard_unit #(.N(N), .A(A), .FWD_EN(1'b1), .CNT_W(32)) dut_f (.clk(clk), .reset(rst_n), .hz(bf));
    pipe_hazard_unit #(.N(N), .A(A), .FWD_EN(1'b0), .CNT_W(2))  dut_s (.clk(clk), .reset(rst_n), .hz(bs));

    assign bf.valid_D = valid_D;     assign bs.valid_D = valid_D;
    assign bf.rs1_D = rs1;           assign bs.rs1_D = rs1;
    assign bf.rs2_D = rs2;           assign bs.rs2_D = rs2;
    assign bf.usesRs1_D = u1;        assign bs.usesRs1_D = u1;
    assign bf.usesRs2_D = u2;        assign bs.usesRs2_D = u2;
    assign bf.rd_D = rd;             assign bs.rd_D = rd;
    assign bf.regWrite_D = rw;       assign bs.regWrite_D = rw;
    assign bf.memRead_D = mr;        assign bs.memRead_D = mr;
    assign bf.PCSrc_E = pc;          assign bs.PCSrc_E = pc;
    assign bf.readData1_E = rd1;     assign bs.readData1_E = rd1;
    assign bf.readData2_E = rd2;     assign bs.readData2_E = rd2;
    assign bf.aluResult_M = alu;     assign bs.aluResult_M = alu;
    assign bf.writeData3_W = wb;     assign bs.writeData3_W = wb;

    // Reference model: the instructions currently in E, M, W for each DUT (index 0 forwarding, 1 stall-only).
    typedef struct { bit v; bit [A-1:0] rs1, rs2; bit u1, u2; bit [A-1:0] rd; bit rw, mr; } instr_t;
    typedef struct { bit stall, fd, fe; bit [1:0] s1, s2; } exp_t;
    typedef struct { bit v; bit [A-1:0] s1, s2; bit a1, a2; bit [A-1:0] d; bit w, m, p;
                     bit stall, fd, fe; bit [1:0] e1, e2; int sc, fc; } vec_t;

    instr_t          pipe [2][3];
    instr_t          BUBBLE;
    longint unsigned scnt [2];
    longint unsigned fcnt [2];
    longint unsigned cmax [2] = '{64'hFFFF_FFFF, 64'd3};
    bit              fwd  [2] = '{1'b1, 1'b0};

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit writes(input instr_t x);
        return x.v && x.rw && (x.rd != 0);
    endfunction

    function automatic bit d_reads(input instr_t x);
        return writes(x) && ((u1 && rs1 == x.rd) || (u2 && rs2 == x.rd));
    endfunction

    function automatic bit [1:0] source_of(input int k, input bit used, input bit [A-1:0] src);
        if (!fwd[k] || !pipe[k][0].v || !used) return 2'b00;
        if (writes(pipe[k][1]) && !pipe[k][1].mr && pipe[k][1].rd == src) return 2'b10;
        if (writes(pipe[k][2]) && pipe[k][2].rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input int k);
        exp_t x;
        bit   haz;
        haz     = fwd[k] ? (d_reads(pipe[k][0]) && pipe[k][0].mr)
                         : (d_reads(pipe[k][0]) || d_reads(pipe[k][1]));
        x.fd    = rst_n && pc;
        x.stall = rst_n && valid_D && haz && !pc;
        x.fe    = x.fd || x.stall;
        x.s1    = source_of(k, pipe[k][0].u1, pipe[k][0].rs1);
        x.s2    = source_of(k, pipe[k][0].u2, pipe[k][0].rs2);
        return x;
    endfunction

    function automatic logic [N-1:0] data_for(input bit [1:0] s, input logic [N-1:0] rf);
        if (s == 2'b10) return alu;
        if (s == 2'b01) return wb;
        return rf;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) pipe[k][i] = BUBBLE;
            scnt[k] = 0;
            fcnt[k] = 0;
        end
    endtask

    task automatic advance(input int k, input exp_t x);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[k][i] = BUBBLE;
            scnt[k] = 0;
            fcnt[k] = 0;
            return;
        end
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        if (valid_D && !x.fe) pipe[k][0] = '{1'b1, rs1, rs2, u1, u2, rd, rw, mr};
        else                  pipe[k][0] = BUBBLE;
        if (x.stall && scnt[k] < cmax[k]) scnt[k]++;
        if (x.fd && fcnt[k] < cmax[k]) fcnt[k]++;
    endtask

    task automatic check_dut(input int k, input string tag, input exp_t x,
                             input logic sf, input logic sd, input logic fd, input logic fe,
                             input logic [1:0] g1, input logic [1:0] g2,
                             input logic [N-1:0] d1, input logic [N-1:0] d2,
                             input logic [63:0] sc, input logic [63:0] fc);
        string p;
        p = $sformatf("%s/dut%0d", tag, k);
        chk({p, ".stall_F"}, 64'(sf), 64'(x.stall));
        chk({p, ".stall_D"}, 64'(sd), 64'(x.stall));
        chk({p, ".flush_D"}, 64'(fd), 64'(x.fd));
        chk({p, ".flush_E"}, 64'(fe), 64'(x.fe));
        chk({p, ".fwdSel1"}, 64'(g1), 64'(x.s1));
        chk({p, ".fwdSel2"}, 64'(g2), 64'(x.s2));
        chk({p, ".fwdData1"}, d1, data_for(x.s1, rd1));
        chk({p, ".fwdData2"}, d2, data_for(x.s2, rd2));
        chk({p, ".stallCount"}, sc, scnt[k]);
        chk({p, ".flushCount"}, fc, fcnt[k]);
    endtask

    // Called at a falling edge: compares both DUTs with the model, then steps the model across the rising edge.
    task automatic eval(input string tag);
        exp_t x0, x1;
        x0 = predict(0);
        x1 = predict(1);
        check_dut(0, tag, x0, bf.stall_F, bf.stall_D, bf.flush_D, bf.flush_E, bf.fwdSel1_E, bf.fwdSel2_E,
                  bf.fwdData1_E, bf.fwdData2_E, 64'(bf.stallCount), 64'(bf.flushCount));
        check_dut(1, tag, x1, bs.stall_F, bs.stall_D, bs.flush_D, bs.flush_E, bs.fwdSel1_E, bs.fwdSel2_E,
                  bs.fwdData1_E, bs.fwdData2_E, 64'(bs.stallCount), 64'(bs.flushCount));
        @(posedge clk);
        advance(0, x0);
        advance(1, x1);
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        eval(tag);
    endtask

    task automatic set_d(input bit v, input bit [A-1:0] s1, input bit [A-1:0] s2, input bit a1,
                         input bit a2, input bit [A-1:0] d, input bit w, input bit m, input bit p);
        valid_D = v; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; rd = d; rw = w; mr = m; pc = p;
        rd1 = {$urandom, $urandom};
        rd2 = {$urandom, $urandom};
        alu = {$urandom, $urandom};
        wb  = {$urandom, $urandom};
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1, 1, 2, 1, 1, 5, 1, 0, 0,   0, 0, 0, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{1, 5, 7, 1, 1, 6, 1, 0, 0,   0, 0, 0, 2'b00, 2'b00, 0, 0};
        tbl[2]  = '{1, 1, 1, 1, 1, 0, 1, 0, 0,   0, 0, 0, 2'b10, 2'b00, 0, 0};
        tbl[3]  = '{1, 0, 0, 1, 1, 8, 1, 0, 0,   0, 0, 0, 2'b00, 2'b00, 0, 0};
        tbl[4]  = '{1, 9, 0, 1, 0, 3, 1, 1, 0,   0, 0, 0, 2'b00, 2'b00, 0, 0};
        tbl[5]  = '{1, 3, 3, 1, 1, 4, 1, 0, 0,   1, 0, 1, 2'b00, 2'b00, 0, 0};
        tbl[6]  = '{1, 3, 3, 1, 1, 4, 1, 0, 0,   0, 0, 0, 2'b00, 2'b00, 1, 0};
        tbl[7]  = '{1, 1, 1, 1, 1, 9, 1, 0, 0,   0, 0, 0, 2'b01, 2'b01, 1, 0};
        tbl[8]  = '{1, 2, 2, 1, 1, 9, 1, 0, 0,   0, 0, 0, 2'b00, 2'b00, 1, 0};
        tbl[9]  = '{1, 9, 9, 1, 1, 10, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1, 0};
        tbl[10] = '{1, 2, 0, 1, 0, 11, 1, 1, 0,  0, 0, 0, 2'b10, 2'b10, 1, 0};
        tbl[11] = '{1, 11, 0, 1, 1, 12, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'b00, 2'b00, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 2'b00, 2'b00, 1, 1};

        clear_model();
        rst_n = 1'b1;
        set_d(1, 3, 3, 1, 1, 4, 1, 1, 1);
        #1 rst_n = 1'b0;

        // Reset held with arbitrary inputs, then released with an empty D stage.
        @(negedge clk);
        chk("rst.stall_D", 64'(bf.stall_D), 64'd0);
        chk("rst.flush_D", 64'(bf.flush_D), 64'd0);
        chk("rst.fwdSel1", 64'(bf.fwdSel1_E), 64'd0);
        chk("rst.fwdData1", bf.fwdData1_E, rd1);
        chk("rst.stallCount", 64'(bs.stallCount), 64'd0);
        eval("rst");
        cycle("rst_hold");
        rst_n = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst_rel0");
        cycle("rst_rel1");

        for (int i = 0; i < 14; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            set_d(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].a1, tbl[i].a2, tbl[i].d, tbl[i].w, tbl[i].m, tbl[i].p);
            @(negedge clk);
            chk({t, ".stall_F"}, 64'(bf.stall_F), 64'(tbl[i].stall));
            chk({t, ".stall_D"}, 64'(bf.stall_D), 64'(tbl[i].stall));
            chk({t, ".flush_D"}, 64'(bf.flush_D), 64'(tbl[i].fd));
            chk({t, ".flush_E"}, 64'(bf.flush_E), 64'(tbl[i].fe));
            chk({t, ".fwdSel1"}, 64'(bf.fwdSel1_E), 64'(tbl[i].e1));
            chk({t, ".fwdSel2"}, 64'(bf.fwdSel2_E), 64'(tbl[i].e2));
            chk({t, ".fwdData1"}, bf.fwdData1_E, tbl[i].e1 == 2'b10 ? alu : tbl[i].e1 == 2'b01 ? wb : rd1);
            chk({t, ".fwdData2"}, bf.fwdData2_E, tbl[i].e2 == 2'b10 ? alu : tbl[i].e2 == 2'b01 ? wb : rd2);
            chk({t, ".stallCount"}, 64'(bf.stallCount), 64'(tbl[i].sc));
            chk({t, ".flushCount"}, 64'(bf.flushCount), 64'(tbl[i].fc));
            eval(t);
        end

        // Asynchronous reset in the middle of a load-use stall.
        set_d(1, 9, 0, 1, 0, 3, 1, 1, 0);
        cycle("mid_ld");
        set_d(1, 3, 3, 1, 1, 4, 1, 0, 0);
        #1 chk("mid.stall_before", 64'(bf.stall_D), 64'd1);
        rst_n = 1'b0;
        pc = 1'b1;
        #1;
        clear_model();
        chk("mid.stall_D", 64'(bf.stall_D), 64'd0);
        chk("mid.flush_D", 64'(bf.flush_D), 64'd0);
        chk("mid.flush_E", 64'(bf.flush_E), 64'd0);
        chk("mid.stallCount", 64'(bf.stallCount), 64'd0);
        cycle("mid_hold");
        rst_n = 1'b1;
        pc = 1'b0;

        // Stall-only instance: each dependent ALU pair costs two stalls; the 2-bit counter sticks at 3.
        for (int r = 0; r < 3; r++) begin
            set_d(1, 1, 2, 1, 1, 5, 1, 0, 0);
            cycle("nf_prod");
            set_d(1, 5, 7, 1, 1, 6, 1, 0, 0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk($sformatf("nf%0d_%0d.stall_D", r, c), 64'(bs.stall_D), c < 2 ? 64'd1 : 64'd0);
                chk($sformatf("nf%0d_%0d.fwdSel1", r, c), 64'(bs.fwdSel1_E), 64'd0);
                eval("nf");
            end
            chk($sformatf("nf%0d.stallCount", r), 64'(bs.stallCount), r == 0 ? 64'd2 : 64'd3);
        end

        // Random traffic over a small register set so hazards and forwards occur often.
        for (int i = 0; i < 400; i++) begin
            set_d($urandom_range(0, 9) < 8, A'($urandom_range(0, 3)), A'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), A'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            cycle($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
